rr_arbiter4: RTL and testbench

Four-requester round-robin arbiter with grant locking and bounded hold time. Produces a registered one-hot grant vector that feeds directly into the 4-to-2 encoder stage, which converts it to a 2-bit requester index. It guarantees that the encoder input is always exactly one-hot or all-zero. Fairness across requesters is enforced by a rotating priority pointer plus a hold-time limit.

---
 rtl/rr_arbiter4_if.sv | 26 ++
 rtl/rr_arbiter4.sv | 131 +++++++++++++
 tb/tb_rr_arbiter4.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if: request/grant bundle between requesters and the round-robin arbiter.
//   req       [3:0]  request vector, bit i = requester i wants access (level-sensitive)
//   gnt       [3:0]  registered one-hot (or zero) grant, bit order matches req
//   gnt_valid        registered, equals |gnt
//   gnt_new          registered, one-cycle pulse on the first cycle of every new grant
// Modports: master = requester side (drives req), slave = arbiter side (drives grants).
interface rr_arbiter4_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic       gnt_new;

   modport master (
      output req,
      input  gnt,
      input  gnt_valid,
      input  gnt_new
   );

   modport slave (
      input  req,
      output gnt,
      output gnt_valid,
      output gnt_new
   );
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with grant locking and a bounded hold time.
// The grant vector is registered and always one-hot or all-zero, so it can feed the 4-to-2
// index encoder directly.
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles for a contended requester (1..255)
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   rr_arbiter4_if.slave: req in; gnt, gnt_valid, gnt_new out (all registered)
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic           clk,
   input  logic           rst,
   rr_arbiter4_if.slave   bus
);

   localparam logic [7:0] HoldMax = 8'(MAX_HOLD);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;          // last granted requester; the holder while in StGrant
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       grant_change;          // next state starts a fresh grant
   logic [3:0] gnt_q, gnt_d;
   logic       gnt_valid_q, gnt_valid_d;
   logic       gnt_new_q, gnt_new_d;

   logic       srch_found;
   logic [1:0] srch_idx;
   logic       others_pending;

   // Returns {found, idx} for the first set bit of r in the order base+1 .. base+4 (mod 4).
   // Iterating from the far end lets the nearest hit overwrite the others.
   function automatic logic [2:0] rr_search(input logic [1:0] base, input logic [3:0] r);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int d = 4; d >= 1; d--) begin
         idx = base + 2'(d);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // One search serves every case: from IDLE it starts after the last grant; while holding it
   // starts after the holder, so the holder itself is only reached last and any competitor
   // wins first (preemption), while a released holder has req[i]=0 and is skipped anyway.
   always_comb begin
      {srch_found, srch_idx} = rr_search(ptr_q, bus.req);
      others_pending         = |(bus.req & ~(4'b0001 << ptr_q));
   end

   // State register, including the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= 2'd3;
         hold_cnt_q  <= 8'd0;
         gnt_q       <= 4'b0000;
         gnt_valid_q <= 1'b0;
         gnt_new_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_new_q   <= gnt_new_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      hold_cnt_d   = hold_cnt_q;
      grant_change = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (srch_found) begin
               state_d      = StGrant;
               ptr_d        = srch_idx;
               hold_cnt_d   = 8'd1;
               grant_change = 1'b1;
            end
         end
         StGrant: begin
            if (!bus.req[ptr_q]) begin
               if (srch_found) begin
                  // Direct hand-over, no idle bubble.
                  ptr_d        = srch_idx;
                  hold_cnt_d   = 8'd1;
                  grant_change = 1'b1;
               end else begin
                  state_d    = StIdle;
                  hold_cnt_d = 8'd0;
               end
            end else if (hold_cnt_q >= HoldMax && others_pending) begin
               ptr_d        = srch_idx;
               hold_cnt_d   = 8'd1;
               grant_change = 1'b1;
            end else if (hold_cnt_q < HoldMax) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output logic, computed from the next state so the outputs come out registered.
   always_comb begin
      gnt_d       = 4'b0000;
      gnt_valid_d = 1'b0;
      gnt_new_d   = grant_change;
      if (state_d == StGrant) begin
         gnt_d       = 4'b0001 << ptr_d;
         gnt_valid_d = 1'b1;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.gnt_new   = gnt_new_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: four arbiter instances (MAX_HOLD = 1, 2, 4, 8) share one request stream
// and are compared every cycle against a behavioural model, plus directed checks.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst;
   logic [3:0] req;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   int mh[4] = '{1, 2, 4, 8};

   rr_arbiter4_if if_mh1 ();
   rr_arbiter4_if if_mh2 ();
   rr_arbiter4_if if_mh4 ();
   rr_arbiter4_if if_mh8 ();

   assign if_mh1.req = req;
   assign if_mh2.req = req;
   assign if_mh4.req = req;
   assign if_mh8.req = req;

   rr_arbiter4 #(.MAX_HOLD(1)) u_mh1 (.clk(clk), .rst(rst), .bus(if_mh1.slave));
   rr_arbiter4 #(.MAX_HOLD(2)) u_mh2 (.clk(clk), .rst(rst), .bus(if_mh2.slave));
   rr_arbiter4 #(.MAX_HOLD(4)) u_mh4 (.clk(clk), .rst(rst), .bus(if_mh4.slave));
   rr_arbiter4 #(.MAX_HOLD(8)) u_mh8 (.clk(clk), .rst(rst), .bus(if_mh8.slave));

   logic [3:0] gnt_o[4];
   logic       vld_o[4];
   logic       new_o[4];

   assign gnt_o[0] = if_mh1.gnt;  assign vld_o[0] = if_mh1.gnt_valid;  assign new_o[0] = if_mh1.gnt_new;
   assign gnt_o[1] = if_mh2.gnt;  assign vld_o[1] = if_mh2.gnt_valid;  assign new_o[1] = if_mh2.gnt_new;
   assign gnt_o[2] = if_mh4.gnt;  assign vld_o[2] = if_mh4.gnt_valid;  assign new_o[2] = if_mh4.gnt_new;
   assign gnt_o[3] = if_mh8.gnt;  assign vld_o[3] = if_mh8.gnt_valid;  assign new_o[3] = if_mh8.gnt_new;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: owner = -1 means idle.
   int owner[4];
   int last[4];
   int held[4];
   bit fresh[4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int rr_next(input int base, input logic [3:0] r);
      for (int d = 1; d <= 4; d++) begin
         if (r[(base + d) % 4]) return (base + d) % 4;
      end
      return -1;
   endfunction

   task automatic model(input logic [3:0] r, input logic rs);
      int w;
      logic [3:0] others;
      for (int k = 0; k < 4; k++) begin
         fresh[k] = 1'b0;
         if (rs) begin
            owner[k] = -1;
            last[k]  = 3;
            held[k]  = 0;
         end else if (owner[k] < 0) begin
            w = rr_next(last[k], r);
            if (w >= 0) begin
               owner[k] = w; last[k] = w; held[k] = 1; fresh[k] = 1'b1;
            end
         end else if (!r[owner[k]]) begin
            w = rr_next(owner[k], r);
            if (w >= 0) begin
               owner[k] = w; last[k] = w; held[k] = 1; fresh[k] = 1'b1;
            end else begin
               owner[k] = -1; held[k] = 0;
            end
         end else begin
            others = r;
            others[owner[k]] = 1'b0;
            if (held[k] >= mh[k] && others != 4'b0000) begin
               w = rr_next(owner[k], others);
               owner[k] = w; last[k] = w; held[k] = 1; fresh[k] = 1'b1;
            end else if (held[k] < mh[k]) begin
               held[k]++;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [3:0] eg;
      for (int k = 0; k < 4; k++) begin
         eg = (owner[k] < 0) ? 4'b0000 : (4'b0001 << owner[k]);
         check($sformatf("gnt mh%0d", mh[k]), 32'(gnt_o[k]), 32'(eg));
         check($sformatf("gnt_valid mh%0d", mh[k]), 32'(vld_o[k]), 32'(owner[k] >= 0));
         check($sformatf("gnt_new mh%0d", mh[k]), 32'(new_o[k]), 32'(fresh[k]));
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then compare #1 after it.
   task automatic step(input logic [3:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      model(r, rs);
      #1;
      cyc++;
      compare_all();
   endtask

   int run4;

   initial begin
      req = 4'b0000;
      rst = 1'b1;

      // Reset with all requesting, then first grant goes to requester 0.
      step(4'b1111, 1'b1);
      step(4'b1111, 1'b1);
      check("reset gnt", 32'(gnt_o[3]), 32'h0);
      check("reset gnt_new", 32'(new_o[3]), 32'h0);
      step(4'b1111, 1'b0);
      check("first gnt", 32'(gnt_o[3]), 32'h1);
      check("first gnt_new", 32'(new_o[3]), 32'h1);

      // Rotation: each holder drops its bit after two grant cycles and re-raises it.
      step(4'b1111, 1'b0);
      step(4'b1110, 1'b0);
      check("rot 0->1", 32'(gnt_o[3]), 32'h2);
      step(4'b1111, 1'b0);
      step(4'b1101, 1'b0);
      check("rot 1->2", 32'(gnt_o[3]), 32'h4);
      step(4'b1111, 1'b0);
      step(4'b1011, 1'b0);
      check("rot 2->3", 32'(gnt_o[3]), 32'h8);
      step(4'b1111, 1'b0);
      step(4'b0111, 1'b0);
      check("rot 3->0", 32'(gnt_o[3]), 32'h1);
      check("rot new", 32'(new_o[3]), 32'h1);

      // Hold limit with MAX_HOLD=4: requester 2 holds for 4 cycles, then requester 0.
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b0);
      run4 = (gnt_o[2] == 4'b0100) ? 1 : 0;
      for (int i = 0; i < 6 && gnt_o[2] == 4'b0100; i++) begin
         step(4'b0101, 1'b0);
         if (gnt_o[2] == 4'b0100) run4++;
      end
      check("hold run length mh4", 32'(run4), 32'd4);
      check("hold preempt gnt", 32'(gnt_o[2]), 32'h1);
      check("hold preempt new", 32'(new_o[2]), 32'h1);
      step(4'b0100, 1'b0);
      check("hold return gnt", 32'(gnt_o[2]), 32'h4);

      // Sole requester keeps the grant indefinitely.
      step(4'b0000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(4'b1000, 1'b0);
         check("sole gnt mh2", 32'(gnt_o[1]), 32'h8);
         check("sole new mh2", 32'(new_o[1]), 32'(i == 0));
      end

      // Release to idle, then wrap from ptr=3 to index 0.
      step(4'b0000, 1'b0);
      check("idle gnt", 32'(gnt_o[3]), 32'h0);
      check("idle valid", 32'(vld_o[3]), 32'h0);
      step(4'b1001, 1'b0);
      check("wrap gnt", 32'(gnt_o[3]), 32'h1);

      // Reset mid-grant.
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b0);
      step(4'b0110, 1'b0);
      check("mid gnt before", 32'(gnt_o[3]), 32'h4);
      step(4'b0110, 1'b1);
      check("mid reset gnt", 32'(gnt_o[3]), 32'h0);
      step(4'b0110, 1'b0);
      check("mid after gnt", 32'(gnt_o[3]), 32'h2);

      // Randomized traffic: each request bit toggles with probability 1/4, rare resets.
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] r;
         r = req;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(3) == 0) r[b] = ~r[b];
         end
         step(r, ($urandom_range(149) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
